// File: rtl/inta_sequencer.sv
// inta_sequencer: interrupt-acknowledge sequencer for an 8259-style controller.
//   Fixed priority (IR0 highest). When an eligible request exists, it raises INT
//   and runs the two-pulse INTA handshake. The first acknowledge edge latches
//   the serviced index, sets its ISR bit and strobes the IRR clear. The second
//   edge drives the vector byte {vectorBase, n}.
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   risedBits[7:0]       pending unmasked IRR requests (bit n = IRn)
//   INTA_n               CPU acknowledge, active low, synchronous to clk
//   EOI                  one-cycle non-specific end-of-interrupt pulse
//   vectorBase[4:0]      ICW2 T7..T3
//   INT                  interrupt request to the CPU
//   readPriority         IRR freeze for the duration of the handshake
//   resetIRR[2:0]        IRR bit to clear, qualified by resetIRRValid
//   resetIRRValid        one-cycle IRR clear strobe
//   inServiceRegister    ISR contents
//   dataBuffer[7:0]      vector byte, dataBufferEnable = drive enable
// Build option: AUTO_EOI_EN -- clear the serviced ISR bit when the second
//   acknowledge pulse is released.
module inta_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] risedBits,
  input  logic       INTA_n,
  input  logic       EOI,
  input  logic [4:0] vectorBase,
  output logic       INT,
  output logic       readPriority,
  output logic [2:0] resetIRR,
  output logic       resetIRRValid,
  output logic [7:0] inServiceRegister,
  output logic [7:0] dataBuffer,
  output logic       dataBufferEnable
);

  typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} state_t;

  state_t     state, state_nxt;
  logic       inta_q;
  logic       ack_edge;
  logic [7:0] isr, isr_set, isr_nxt;
  logic [7:0] isr_low, prio_mask, eligible;
  logic       any_elig;
  logic [2:0] elig_idx;
  logic [2:0] vec_idx, vec_idx_nxt;
  logic [2:0] irr_idx_nxt;
  logic       strobe_nxt;
`ifdef AUTO_EOI_EN
  logic       spur, spur_nxt;
`endif

  assign ack_edge = !INTA_n && inta_q;

  // A request is eligible only if it is strictly above the highest-priority
  // in-service bit. Isolating the lowest set ISR bit and subtracting one gives
  // a mask of all higher-priority positions. ISR=0 wraps the mask to 8'hFF.
  assign isr_low   = isr & (~isr + 8'd1);
  assign prio_mask = isr_low - 8'd1;
  assign eligible  = risedBits & prio_mask;
  assign any_elig  = |eligible;

  // Lowest index wins; 7 is the default, which also serves as the spurious index.
  always_comb begin
    elig_idx = 3'd7;
    for (int i = 7; i >= 0; i--)
      if (eligible[i]) elig_idx = 3'(i);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt   = state;
    vec_idx_nxt = vec_idx;
    irr_idx_nxt = resetIRR;
    strobe_nxt  = 1'b0;
    isr_set     = isr;
`ifdef AUTO_EOI_EN
    spur_nxt    = spur;
`endif
    case (state)
      IDLE:  if (any_elig) state_nxt = PEND;
      PEND:  if (ack_edge) begin
               state_nxt   = ACK1;
               vec_idx_nxt = elig_idx;
`ifdef AUTO_EOI_EN
               spur_nxt    = !any_elig;
`endif
               if (any_elig) begin
                 isr_set     = isr | (8'd1 << elig_idx);
                 strobe_nxt  = 1'b1;
                 irr_idx_nxt = elig_idx;
               end
             end
      ACK1:  if (INTA_n) state_nxt = WAIT2;
      WAIT2: if (ack_edge) state_nxt = ACK2;
      ACK2:  if (INTA_n) begin
               state_nxt = IDLE;
`ifdef AUTO_EOI_EN
               if (!spur) isr_set = isr & ~(8'd1 << vec_idx);
`endif
             end
      default: state_nxt = IDLE;
    endcase
    // EOI acts on the ISR after any same-cycle set/clear from the handshake.
    isr_nxt = EOI ? (isr_set & (isr_set - 8'd1)) : isr_set;

    INT              = (state == PEND) || (state == ACK1) || (state == WAIT2);
    readPriority     = (state == ACK1) || (state == WAIT2) || (state == ACK2);
    dataBufferEnable = (state == ACK2) && !INTA_n;
    dataBuffer       = dataBufferEnable ? {vectorBase, vec_idx} : 8'h00;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      inta_q        <= 1'b1;
      isr           <= 8'h00;
      vec_idx       <= 3'd0;
      resetIRR      <= 3'd0;
      resetIRRValid <= 1'b0;
`ifdef AUTO_EOI_EN
      spur          <= 1'b0;
`endif
    end else begin
      inta_q        <= INTA_n;
      isr           <= isr_nxt;
      vec_idx       <= vec_idx_nxt;
      resetIRR      <= irr_idx_nxt;
      resetIRRValid <= strobe_nxt;
`ifdef AUTO_EOI_EN
      spur          <= spur_nxt;
`endif
    end

  assign inServiceRegister = isr;

endmodule
